// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the default operand width.
package div_pkg;

    localparam int DIV_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Operand/result handshake bundle of div_seq; the producer/consumer side uses
// master, the divider uses slave.
interface div_seq_if import div_pkg::*; #(parameter int W = DIV_W);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic         ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem, quo} left,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step import div_pkg::*; #(
    parameter int W = DIV_W
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic [W-1:0] quo_next
);

    logic [W+1:0] shifted_s;
    logic [W+1:0] diff_s;

    // Trial subtract; bit W+1 of the difference is the borrow.
    always_comb begin
        shifted_s = {rem, quo[W-1]};
        diff_s    = shifted_s - {2'b00, divisor};
        if (diff_s[W+1]) begin
            rem_next = shifted_s[W:0];
            quo_next = {quo[W-2:0], 1'b0};
        end else begin
            rem_next = diff_s[W:0];
            quo_next = {quo[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider (restoring, radix-2) with valid/ready handshake.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the iteration phase.
module div_seq import div_pkg::*; #(
    parameter int W = DIV_W
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    localparam int CW = $clog2(W + 1);

    div_state_t   state_r;
    div_state_t   state_nxt_s;
    logic [W:0]   rem_r;
    logic [W-1:0] quo_r;
    logic [W-1:0] dvsr_r;
    logic [W-1:0] dividend_r;
    logic         neg_q_r;
    logic         neg_r_r;
    logic         dbz_flag_r;
    logic         ovf_flag_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0] quotient_r;
    logic [W-1:0] remainder_r;
    logic         dbz_r;
    logic         ovf_r;
    logic [W:0]   rem_nxt_s;
    logic [W-1:0] quo_nxt_s;
    logic         in_ready_s;
    logic         out_valid_s;
    logic         div_zero_s;
    logic         ovf_case_s;

    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        return ~v + W'(1);
    endfunction

    // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? negate(v) : v;
    endfunction

    assign div_zero_s = (bus.divisor == {W{1'b0}});
    assign ovf_case_s = (bus.dividend == {1'b1, {(W-1){1'b0}}}) &&
                        (bus.divisor == {W{1'b1}});

    div_step #(.W(W)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvsr_r),
        .rem_next (rem_nxt_s),
        .quo_next (quo_nxt_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; CALC spends one extra cycle at count zero before FIX.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_nxt_s = div_zero_s ? ST_FIX : ST_CALC;
`else
                    state_nxt_s = ST_CALC;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s  = 1'b1;
            ST_DONE: out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r       <= {(W+1){1'b0}};
            quo_r       <= {W{1'b0}};
            dvsr_r      <= {W{1'b0}};
            dividend_r  <= {W{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dbz_flag_r  <= 1'b0;
            ovf_flag_r  <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        rem_r      <= {(W+1){1'b0}};
                        quo_r      <= magnitude(bus.dividend);
                        dvsr_r     <= magnitude(bus.divisor);
                        dividend_r <= bus.dividend;
                        neg_q_r    <= bus.dividend[W-1] ^ bus.divisor[W-1];
                        neg_r_r    <= bus.dividend[W-1];
                        dbz_flag_r <= div_zero_s;
                        ovf_flag_r <= ovf_case_s;
                        cnt_r      <= CW'(W);
                    end
                end
                ST_CALC: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (dbz_flag_r) begin
                        quotient_r  <= {W{1'b1}};
                        remainder_r <= dividend_r;
                    end else begin
                        quotient_r  <= neg_q_r ? negate(quo_r) : quo_r;
                        remainder_r <= neg_r_r ? negate(rem_r[W-1:0]) : rem_r[W-1:0];
                    end
                    dbz_r <= dbz_flag_r;
                    ovf_r <= ovf_flag_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed sign/corner cases plus random
// operands against an integer-arithmetic reference model.
module tb_div_seq;
    import div_pkg::*;

    localparam int W     = 17;
    localparam int MIN_V = -(32'sd1 <<< (W - 1));

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_seq_if #(.W(W)) bus ();

    div_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one division from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit poke);
        int sa, sb, q, r, lat, exp_lat, wait_n;
        logic [W-1:0] eq, er;
        logic edbz, eovf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            eq = {W{1'b1}};
            er = a;
            edbz = 1'b1;
            eovf = 1'b0;
            exp_lat = 19;
`ifdef DIV_ZERO_BYPASS_EN
            exp_lat = 1;
`endif
        end else begin
            q = sa / sb;
            r = sa % sb;
            eq = q[W-1:0];
            er = r[W-1:0];
            edbz = 1'b0;
            eovf = (sa == MIN_V) && (sb == -1);
            exp_lat = 19;
        end

        wait_n = 0;
        while (!bus.in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("ready_idle", 32'(bus.in_ready), 32'd1);

        bus.out_ready = (hold == 0);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (poke && lat == 4) begin
                bus.dividend = ~a;
                bus.divisor  = 17'd1;
                bus.in_valid = 1'b1;
                check_eq("busy_ready", 32'(bus.in_ready), 32'd0);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;

        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("quotient", 32'(bus.quotient), 32'(eq));
        check_eq("remainder", 32'(bus.remainder), 32'(er));
        check_eq("dbz", 32'(bus.dbz), 32'(edbz));
        check_eq("ovf", 32'(bus.ovf), 32'(eovf));
        check_eq("ready_done", 32'(bus.in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_quot", 32'(bus.quotient), 32'(eq));
            check_eq("hold_rem", 32'(bus.remainder), 32'(er));
            check_eq("hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("valid_drop", 32'(bus.out_valid), 32'd0);
        check_eq("ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int hold;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = {W{1'b0}};
        bus.divisor   = {W{1'b0}};
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_quot", 32'(bus.quotient), 32'd0);
        check_eq("rst_rem", 32'(bus.remainder), 32'd0);
        check_eq("rst_dbz", 32'(bus.dbz), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(17'd100, 17'd7, 0, 1'b0);
        do_op(-17'sd100, 17'd7, 0, 1'b0);
        do_op(17'd100, -17'sd7, 0, 1'b0);
        do_op(-17'sd100, -17'sd7, 0, 1'b0);
        do_op(17'h10000, 17'h1FFFF, 0, 1'b0);
        do_op(17'd5, 17'd0, 0, 1'b0);
        do_op(17'd12345, 17'd67, 10, 1'b1);
        do_op(17'h10000, 17'd1, 0, 1'b0);
        do_op(17'h0FFFF, 17'h10000, 0, 1'b0);

        // Reset in the middle of an iteration.
        bus.dividend = 17'd999;
        bus.divisor  = 17'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_eq("midrst_ready2", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        do_op(17'd100, 17'd7, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = {W{1'b0}};
                1: rb = {W{1'b1}};
                2: rb = W'($urandom_range(1, 9));
                3: begin
                    ra = 17'h10000;
                    rb = W'($urandom);
                end
                default: rb = W'($urandom);
            endcase
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(ra, rb, hold, ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
